// File: rtl/psdsqrt_seq_if.sv
// Square-root unit bus: start/stop control, operand in, root/remainder/status out.
// master drives start, stop, xin; slave returns sqrt, rem, busy, done.
interface psdsqrt_seq_if #(
  parameter int NUMBITS = 32
);
  localparam int R = NUMBITS / 2;

  logic               start;
  logic               stop;
  logic [NUMBITS-1:0] xin;
  logic [R-1:0]       sqrt;
  logic [R:0]         rem;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output stop,
    output xin,
    input  sqrt,
    input  rem,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    input  xin,
    output sqrt,
    output rem,
    output busy,
    output done
  );
endinterface

// File: rtl/psdsqrt_seq.sv
// Iterative restoring integer square root, one root bit per clock.
// Ports: clock, reset (sync, active-low), bus (slave: start/stop/xin in; sqrt/rem/busy/done out).
module psdsqrt_seq #(
  parameter int NUMBITS = 32,
  parameter int ROUND   = 0
) (
  input  logic        clock,
  input  logic        reset,
  psdsqrt_seq_if.slave bus
);
  localparam int R  = NUMBITS / 2;
  localparam int CW = $clog2(R + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [NUMBITS-1:0] op_q, op_d;
  logic [R-1:0]       root_q, root_d;
  logic [R:0]         prem_q, prem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [R-1:0]       res_q, res_d;
  logic [R:0]         frem_q, frem_d;
  logic [R-1:0]       sqrt_q, sqrt_d;
  logic [R:0]         rem_q, rem_d;

  logic               last;
  logic [R+1:0]       prem_sh;
  logic [R+1:0]       trial;
  logic [R+1:0]       diff;
  logic               ge;
  logic [R-1:0]       it_root;
  logic [R+1:0]       it_rem;
  logic               rnd_up;
  logic [R-1:0]       res_fin;

  assign last = (cnt_q == CW'(1));

  // state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; start wins in every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.start)  state_d = S_RUN;
        else if (last)  state_d = S_DONE;
      end
      S_DONE: begin
        state_d = bus.start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN):  bus.busy = 1'b1;
      (state_q == S_DONE): bus.done = 1'b1;
      default: ;
    endcase
  end

  // one recurrence step: bring down two bits, try (root<<2)|1
  always_comb begin
    prem_sh = {prem_q[R-1:0], op_q[NUMBITS-1 -: 2]};
    trial   = {root_q, 2'b01};
    ge      = (prem_sh >= trial);
    diff    = prem_sh - trial;
    it_root = {root_q[R-2:0], ge};
    it_rem  = ge ? diff : prem_sh;
  end

  // x >= (q + 1/2)^2 reduces to r > q for integers
  always_comb begin
    rnd_up  = (ROUND != 0) &&
              (it_rem > {2'b00, it_root}) &&
              (it_root != {R{1'b1}});
    res_fin = it_root + {{(R-1){1'b0}}, rnd_up};
  end

  // datapath next state
  always_comb begin
    op_d   = op_q;
    root_d = root_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    frem_d = frem_q;
    sqrt_d = sqrt_q;
    rem_d  = rem_q;

    // mid-run stop exposes the unrounded partial result
    if (bus.stop) begin
      if (state_q == S_RUN) begin
        sqrt_d = root_q;
        rem_d  = prem_q;
      end else begin
        sqrt_d = res_q;
        rem_d  = frem_q;
      end
    end

    if (bus.start) begin
      op_d   = bus.xin;
      root_d = '0;
      prem_d = '0;
      cnt_d  = CW'(R);
    end else if (state_q == S_RUN) begin
      op_d   = {op_q[NUMBITS-3:0], 2'b00};
      root_d = it_root;
      prem_d = it_rem[R:0];
      cnt_d  = cnt_q - CW'(1);
      if (last) begin
        res_d  = res_fin;
        frem_d = it_rem[R:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q   <= '0;
      root_q <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      frem_q <= '0;
      sqrt_q <= '0;
      rem_q  <= '0;
    end else begin
      op_q   <= op_d;
      root_q <= root_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      frem_q <= frem_d;
      sqrt_q <= sqrt_d;
      rem_q  <= rem_d;
    end
  end

  assign bus.sqrt = sqrt_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Directed bench for psdsqrt_seq: floor and rounding instances side by side.
// Checks latency, busy span, results, mid-run stop, restart and reset abort.
module tb_psdsqrt_seq;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  psdsqrt_seq_if #(.NUMBITS(32)) b0 ();
  psdsqrt_seq_if #(.NUMBITS(32)) b1 ();

  psdsqrt_seq #(.NUMBITS(32), .ROUND(0)) u0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0.slave)
  );

  psdsqrt_seq #(.NUMBITS(32), .ROUND(1)) u1 (
    .clock (clock),
    .reset (reset),
    .bus   (b1.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? b0.busy : b1.busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? b0.done : b1.done;
  endfunction

  // start, then sample after each edge until done; lat counts cycles
  task automatic go(input int sel, input logic [31:0] x,
                    output int lat, output int bcnt);
    if (sel == 0) begin
      b0.xin = x; b0.start = 1'b1;
    end else begin
      b1.xin = x; b1.start = 1'b1;
    end
    tick;
    b0.start = 1'b0;
    b1.start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (lat < 40) begin
      if (busy_of(sel)) bcnt++;
      if (done_of(sel)) break;
      tick;
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 64'(lat), 64'd17);
  endtask

  task automatic pstop(input int sel);
    if (sel == 0) b0.stop = 1'b1;
    else          b1.stop = 1'b1;
    tick;
    b0.stop = 1'b0;
    b1.stop = 1'b0;
  endtask

  initial begin
    int lat;
    int bc;
    int nd;
    reset = 1'b0;
    b0.start = 1'b0; b0.stop = 1'b0; b0.xin = '0;
    b1.start = 1'b0; b1.stop = 1'b0; b1.xin = '0;
    tick;
    tick;
    reset = 1'b1;
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    chk("rst_sqrt", 64'(b0.sqrt), 64'd0);
    chk("rst_rem",  64'(b0.rem),  64'd0);

    // floor mode basics
    go(0, 32'd17, lat, bc);
    chk("lat17", 64'(lat), 64'd17);
    chk("busy16", 64'(bc), 64'd16);
    pstop(0);
    chk("sq17", 64'(b0.sqrt), 64'd4);
    chk("rm17", 64'(b0.rem),  64'd1);
    chk("done_one", 64'(b0.done), 64'd0);

    go(0, 32'd0, lat, bc);
    pstop(0);
    chk("sq0", 64'(b0.sqrt), 64'd0);
    chk("rm0", 64'(b0.rem),  64'd0);

    go(0, 32'hFFFF_FFFF, lat, bc);
    pstop(0);
    chk("sqmax", 64'(b0.sqrt), 64'd65535);
    chk("rmmax", 64'(b0.rem),  64'd131070);

    // rounding mode
    go(1, 32'd20, lat, bc);
    pstop(1);
    chk("r_sq20", 64'(b1.sqrt), 64'd4);
    go(1, 32'd21, lat, bc);
    pstop(1);
    chk("r_sq21", 64'(b1.sqrt), 64'd5);
    chk("r_rm21", 64'(b1.rem),  64'd5);
    go(1, 32'hFFFF_FFFF, lat, bc);
    pstop(1);
    chk("r_sqmax", 64'(b1.sqrt), 64'd65535);
    chk("r_rmmax", 64'(b1.rem),  64'd131070);

    // stop on 5th edge after start: partial root of 0xFF
    b0.xin = 32'hFFFF_FFFF; b0.start = 1'b1;
    tick;
    b0.start = 1'b0;
    tick; tick; tick; tick;
    pstop(0);
    chk("mid_sq", 64'(b0.sqrt), 64'd15);
    chk("mid_rm", 64'(b0.rem),  64'd30);
    chk("mid_busy", 64'(b0.busy), 64'd1);
    nd = 0;
    while (!b0.done && nd < 40) begin
      tick;
      nd++;
    end
    chk("mid_done_seen", 64'(b0.done), 64'd1);
    pstop(0);
    chk("mid_final", 64'(b0.sqrt), 64'd65535);

    // stop on the last iteration edge sees R-1 iterations
    b0.xin = 32'hFFFF_FFFF; b0.start = 1'b1;
    tick;
    b0.start = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    pstop(0);
    chk("er_sq", 64'(b0.sqrt), 64'd32767);
    chk("er_rm", 64'(b0.rem),  64'd65534);
    chk("er_done", 64'(b0.done), 64'd1);
    tick;

    // restart three cycles later
    b0.xin = 32'hFFFF_FFFF; b0.start = 1'b1;
    tick;
    b0.start = 1'b0;
    nd = 0;
    if (b0.done) nd++;
    tick;
    if (b0.done) nd++;
    tick;
    if (b0.done) nd++;
    go(0, 32'd100, lat, bc);
    chk("rs_early_done", 64'(nd), 64'd0);
    chk("rs_lat", 64'(lat), 64'd17);
    pstop(0);
    chk("rs_sq", 64'(b0.sqrt), 64'd10);
    chk("rs_rm", 64'(b0.rem),  64'd0);

    // reset mid-run aborts and clears everything
    b0.xin = 32'hFFFF_FFFF; b0.start = 1'b1;
    tick;
    b0.start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("ar_busy", 64'(b0.busy), 64'd0);
    chk("ar_done", 64'(b0.done), 64'd0);
    chk("ar_sqrt", 64'(b0.sqrt), 64'd0);
    chk("ar_rem",  64'(b0.rem),  64'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0.done) nd++;
      tick;
    end
    chk("ar_nodone", 64'(nd), 64'd0);
    pstop(0);
    chk("ar_res0", 64'(b0.sqrt), 64'd0);
    go(0, 32'd49, lat, bc);
    pstop(0);
    chk("sq49", 64'(b0.sqrt), 64'd7);
    chk("rm49", 64'(b0.rem),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
